// File: rtl/axis_merger_pkg.sv
// axis_merger_pkg: arbiter states and source/arbitration constants for the AXIS packet merger
package axis_merger_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT0, ST_GRANT1} arb_state_t;
  localparam logic SRC_S00   = 1'b0;
  localparam logic SRC_S01   = 1'b1;
  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: 2-entry skid buffer; in_ready is a flop, out_* are flops, 1-cycle latency
module axis_reg_slice #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_payload
);
  logic          skid_valid;
  logic [PW-1:0] skid_payload;
  assign in_ready = !skid_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_payload  <= '0;
      skid_valid   <= 1'b0;
      skid_payload <= '0;
    end else if (out_ready || !out_valid) begin
      out_valid   <= skid_valid || in_valid;
      out_payload <= skid_valid ? skid_payload : in_payload;
      skid_valid  <= 1'b0;
    end else if (in_valid && !skid_valid) begin
      skid_valid   <= 1'b1;
      skid_payload <= in_payload;
    end
endmodule

// File: rtl/axis_packet_merger.sv
// axis_packet_merger: 2:1 whole-packet AXIS merger (round-robin or fixed priority).
// Define AXIS_MERGER_SRC_ID_EN to add m00_axis_tid carrying the source index of each beat.
module axis_packet_merger
  import axis_merger_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                          axis_aclk,
  input  logic                          axis_aresetn,
  input  logic                          arb_priority,
  output logic                          s00_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                          s00_axis_tlast,
  input  logic                          s00_axis_tvalid,
  output logic                          s01_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                          s01_axis_tlast,
  input  logic                          s01_axis_tvalid,
  output logic                          m00_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                          m00_axis_tlast,
  input  logic                          m00_axis_tready
`ifdef AXIS_MERGER_SRC_ID_EN
  ,
  output logic                          m00_axis_tid
`endif
);
`ifdef AXIS_MERGER_SRC_ID_EN
  localparam int IDW = 1;
`else
  localparam int IDW = 0;
`endif
  localparam int PW = AXIS_TDATA_WIDTH + AXIS_TDATA_WIDTH / 8 + 1 + IDW;
  arb_state_t    state;
  logic          rr_last, sel, in_valid, in_last, slice_in_ready;
  logic [PW-1:0] in_payload, out_payload;
  assign sel             = state == ST_GRANT1;
  assign s00_axis_tready = state == ST_GRANT0 && slice_in_ready;
  assign s01_axis_tready = state == ST_GRANT1 && slice_in_ready;
  assign in_valid        = sel ? s01_axis_tvalid && s01_axis_tready : s00_axis_tvalid && s00_axis_tready;
  assign in_last         = sel ? s01_axis_tlast : s00_axis_tlast;
`ifdef AXIS_MERGER_SRC_ID_EN
  assign in_payload = {sel, in_last, sel ? s01_axis_tstrb : s00_axis_tstrb, sel ? s01_axis_tdata : s00_axis_tdata};
  assign {m00_axis_tid, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} = out_payload;
`else
  assign in_payload = {in_last, sel ? s01_axis_tstrb : s00_axis_tstrb, sel ? s01_axis_tdata : s00_axis_tdata};
  assign {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} = out_payload;
`endif
  // rr_last records the source that completed the most recent packet; reset favours s00
  always_ff @(posedge axis_aclk or negedge axis_aresetn)
    if (!axis_aresetn) begin
      state   <= ST_IDLE;
      rr_last <= SRC_S01;
    end else
      case (state)
        ST_IDLE:
          if (s00_axis_tvalid && s01_axis_tvalid)
            state <= (arb_priority == ARB_FIXED || rr_last == SRC_S01) ? ST_GRANT0 : ST_GRANT1;
          else if (s00_axis_tvalid)
            state <= ST_GRANT0;
          else if (s01_axis_tvalid)
            state <= ST_GRANT1;
        default:
          if (in_valid && in_last) begin
            state   <= ST_IDLE;
            rr_last <= sel;
          end
      endcase
  axis_reg_slice #(.PW(PW)) u_slice (
    .clk        (axis_aclk),
    .rst_n      (axis_aresetn),
    .in_valid   (in_valid),
    .in_ready   (slice_in_ready),
    .in_payload (in_payload),
    .out_valid  (m00_axis_tvalid),
    .out_ready  (m00_axis_tready),
    .out_payload(out_payload)
  );
endmodule

// File: tb/tb_axis_packet_merger.sv
// tb_axis_packet_merger: packet-level arbitration model plus per-cycle scoreboard for axis_packet_merger
module tb_axis_packet_merger;
  localparam int W = 32;
  typedef struct packed {
    logic [W-1:0]   data;
    logic [W/8-1:0] strb;
    logic           last;
    logic           tid;
  } beat_t;
  logic clk = 0, rst_n = 0, arb = 0;
  logic s0_rdy, s0_v = 0, s0_last = 0, s1_rdy, s1_v = 0, s1_last = 0;
  logic [W-1:0] s0_d = '0, s1_d = '0, m_d;
  logic [W/8-1:0] s0_s = '0, s1_s = '0, m_s;
  logic m_v, m_last, m_tid, m_rdy = 0;
  beat_t q0[$], q1[$], st0[$], st1[$], exp_q[$];
  logic [W-1:0] dlog[$];
  logic tlog[$];
  int n_cmp = 0, n_err = 0, cyc = 0, out_cnt = 0, t_v = -1, t_m = -1;
  logic acc0 = 0, acc1 = 0, acc_tl = 0, prev_tl = 0, mlast = 1, chk_s01 = 0, tog = 0, hold = 0;
  logic [W+W/8+1:0] held = '0;
  always #5 clk = ~clk;
  axis_packet_merger #(.AXIS_TDATA_WIDTH(W)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n), .arb_priority(arb),
    .s00_axis_tready(s0_rdy), .s00_axis_tdata(s0_d), .s00_axis_tstrb(s0_s),
    .s00_axis_tlast(s0_last), .s00_axis_tvalid(s0_v),
    .s01_axis_tready(s1_rdy), .s01_axis_tdata(s1_d), .s01_axis_tstrb(s1_s),
    .s01_axis_tlast(s1_last), .s01_axis_tvalid(s1_v),
    .m00_axis_tvalid(m_v), .m00_axis_tdata(m_d), .m00_axis_tstrb(m_s),
    .m00_axis_tlast(m_last), .m00_axis_tready(m_rdy)
`ifdef AXIS_MERGER_SRC_ID_EN
    , .m00_axis_tid(m_tid)
`endif
  );
`ifndef AXIS_MERGER_SRC_ID_EN
  assign m_tid = 1'b0;
`endif
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    acc0   <= s0_v && s0_rdy;
    acc1   <= s1_v && s1_rdy;
    acc_tl <= (s0_v && s0_rdy && s0_last) || (s1_v && s1_rdy && s1_last);
  end
  // sources, sink ready and the scoreboard all act on the falling edge
  always @(negedge clk) begin
    if (acc0 && q0.size() > 0) q0.delete(0);
    if (acc1 && q1.size() > 0) q1.delete(0);
    if (prev_tl) chk("idle_gap_after_tlast", {63'b0, acc0 | acc1}, 64'd0);
    prev_tl = acc_tl;
    s0_v = q0.size() > 0;
    s1_v = q1.size() > 0;
    if (s0_v) {s0_d, s0_s, s0_last} = {q0[0].data, q0[0].strb, q0[0].last};
    if (s1_v) {s1_d, s1_s, s1_last} = {q1[0].data, q1[0].strb, q1[0].last};
    if (s0_v && t_v < 0) t_v = cyc;
    if (m_v && t_m < 0) t_m = cyc;
    m_rdy = tog ? !m_rdy : 1'b1;
    if (chk_s01 && q0.size() > 0) chk("s01_tready_blocked", {63'b0, s1_rdy}, 64'd0);
    if (hold && rst_n) begin
      chk("stall_valid", {63'b0, m_v}, 64'd1);
      chk("stall_payload", {26'b0, m_d, m_s, m_last, m_tid}, {26'b0, held});
    end
    hold = m_v && !m_rdy && rst_n;
    held = {m_d, m_s, m_last, m_tid};
    if (m_v && m_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_beat: got data %0h want no beat", m_d);
      end else begin
        chk("data", {32'b0, m_d}, {32'b0, exp_q[0].data});
        chk("strb", {60'b0, m_s}, {60'b0, exp_q[0].strb});
        chk("last", {63'b0, m_last}, {63'b0, exp_q[0].last});
`ifdef AXIS_MERGER_SRC_ID_EN
        chk("tid", {63'b0, m_tid}, {63'b0, exp_q[0].tid});
`endif
        exp_q.delete(0);
      end
      dlog.push_back(m_d);
      tlog.push_back(m_tid);
      out_cnt++;
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic add_pkt(input int src, input int base, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = W'(base + i);
      b.strb = (i == len - 1) ? 4'h7 : 4'hF;
      b.last = i == len - 1;
      b.tid  = src[0];
      if (src == 0) st0.push_back(b);
      else st1.push_back(b);
    end
  endtask
  // packet-level arbitration: whole packets chosen by the priority/round-robin rule
  task automatic launch();
    int ia = 0, ib = 0;
    logic src, done;
    beat_t b;
    while (ia < st0.size() || ib < st1.size()) begin
      src  = ia >= st0.size() ? 1'b1 : ib >= st1.size() ? 1'b0 : (arb ? 1'b0 : !mlast);
      done = 0;
      while (!done) begin
        if (src) begin b = st1[ib]; ib++; end
        else begin b = st0[ia]; ia++; end
        exp_q.push_back(b);
        done = b.last;
      end
      mlast = src;
    end
    foreach (st0[i]) q0.push_back(st0[i]);
    foreach (st1[i]) q1.push_back(st1[i]);
    st0.delete();
    st1.delete();
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0) && n < 500) begin
      step(1);
      n++;
    end
    chk({nm, "_drain_in_time"}, {63'b0, n < 500}, 64'd1);
    step(3);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_m_tvalid"}, {63'b0, m_v}, 64'd0);
    chk({nm, "_m_tdata"}, {32'b0, m_d}, 64'd0);
    chk({nm, "_m_tstrb"}, {60'b0, m_s}, 64'd0);
    chk({nm, "_m_tlast"}, {63'b0, m_last}, 64'd0);
    chk({nm, "_m_tid"}, {63'b0, m_tid}, 64'd0);
    chk({nm, "_s00_tready"}, {63'b0, s0_rdy}, 64'd0);
    chk({nm, "_s01_tready"}, {63'b0, s1_rdy}, 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
  initial begin
    int s, c0, n;
    step(2);
    chk_zero("reset");
    rst_n = 1;
    step(2);
    // round-robin, both sources loaded: s00,s01,s00,s01
    s = dlog.size();
    add_pkt(0, 'h21, 3); add_pkt(0, 'h24, 3);
    add_pkt(1, 'h31, 3); add_pkt(1, 'h34, 3);
    launch();
    drain("t2");
    chk("t2_pkt0", {32'b0, dlog[s]}, 64'h21);
    chk("t2_pkt1", {32'b0, dlog[s+3]}, 64'h31);
    chk("t2_pkt2", {32'b0, dlog[s+6]}, 64'h24);
    chk("t2_pkt3", {32'b0, dlog[s+9]}, 64'h34);
    // single 4-beat packet from s00
    s = dlog.size(); t_v = -1; t_m = -1; chk_s01 = 1;
    add_pkt(0, 'h11, 4);
    launch();
    drain("t1");
    chk_s01 = 0;
    for (int i = 0; i < 4; i++) chk("t1_beat", {32'b0, dlog[s+i]}, 64'(32'h11 + i));
    chk("t1_latency", 64'(t_m - t_v), 64'd2);
    // fixed priority starves s01 while s00 has packets
    arb = 1; chk_s01 = 1; s = dlog.size();
    add_pkt(0, 'h71, 3); add_pkt(0, 'h74, 3); add_pkt(0, 'h77, 3);
    add_pkt(1, 'h81, 3); add_pkt(1, 'h84, 3);
    launch();
    drain("t3");
    chk_s01 = 0; arb = 0;
    chk("t3_s00_last", {32'b0, dlog[s+8]}, 64'h79);
    chk("t3_first_s01", {32'b0, dlog[s+9]}, 64'h81);
    // downstream ready toggling during an 8-beat packet
    tog = 1; s = dlog.size();
    add_pkt(0, 'h41, 8);
    launch();
    drain("t4");
    tog = 0;
    chk("t4_count", 64'(dlog.size() - s), 64'd8);
    for (int i = 0; i < 8; i++) chk("t4_beat", {32'b0, dlog[s+i]}, 64'(32'h41 + i));
    // reset after beat 2 of a 5-beat packet
    s = dlog.size(); c0 = out_cnt; n = 0;
    add_pkt(0, 'h51, 5);
    launch();
    while (out_cnt < c0 + 2 && n < 100) begin step(1); n++; end
    chk("t5_two_beats_in_time", {63'b0, n < 100}, 64'd1);
    rst_n = 0;
    q0.delete(); q1.delete(); exp_q.delete(); mlast = 1;
    step(1);
    chk_zero("t5_reset");
    rst_n = 1;
    step(1);
    add_pkt(1, 'h61, 3);
    launch();
    drain("t5");
    chk("t5_count", 64'(dlog.size() - s), 64'd5);
    chk("t5_beat1", {32'b0, dlog[s+1]}, 64'h52);
    for (int i = 0; i < 3; i++) chk("t5_new_pkt", {32'b0, dlog[s+2+i]}, 64'(32'h61 + i));
    // alternating single-beat packets
    s = dlog.size();
    add_pkt(0, 'hA0, 1); add_pkt(1, 'hB0, 1); add_pkt(0, 'hA1, 1); add_pkt(1, 'hB1, 1);
    launch();
    drain("t6");
    chk("t6_d0", {32'b0, dlog[s]}, 64'hA0);
    chk("t6_d1", {32'b0, dlog[s+1]}, 64'hB0);
    chk("t6_d2", {32'b0, dlog[s+2]}, 64'hA1);
    chk("t6_d3", {32'b0, dlog[s+3]}, 64'hB1);
`ifdef AXIS_MERGER_SRC_ID_EN
    for (int i = 0; i < 4; i++) chk("t6_tid", {63'b0, tlog[s+i]}, 64'(i % 2));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
